mlp_layer_sequencer: RTL and testbench
======================================

Name: mlp_layer_sequencer

Overview:
- Sequences the two-layer MLP inference over the 64-bank SRAM array:
  - Layer 1: 784 inputs x 200 hidden neurons, using input SRAM and weight SRAM 1.
  - Layer 2: 200 hidden x 10 outputs, using intermediate SRAM and weight SRAM 2.
- Generates all SRAM addresses, lane masks and MAC control strobes.
- Takes the reduced sum from the external 64-lane MAC/adder tree, rescales it and writes it back.
- Sits between the top-level host handshake and the SRAM/MAC datapath.

Parameters:
- N_IN_ROWS, 13: input-SRAM rows per layer-1 neuron (last row valid on lanes 0..15 only).
- N_HID, 200: hidden neurons.
- N_MID_ROWS, 4: intermediate-SRAM rows per layer-2 neuron (last row valid on lanes 0..7 only).
- N_OUT, 10: output neurons.
- DRAIN_CYC, 3: cycles from the last acc_en until sum_in is valid.
- ACC_W, 32: accumulator/sum width.
- FRAC_BITS, 8: fixed-point fraction bits removed on writeback.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins inference when idle.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last output is emitted.
- io_addr  out  4  input-SRAM row address.
- w_addr  out  12  weight-SRAM address, shared by both weight arrays.
- w_sel  out  1  0 = weight SRAM 1 / input data; 1 = weight SRAM 2 / intermediate data.
- mid_addr  out  2  intermediate-SRAM address (read in layer 2, write in layer 1).
- mid_we  out  64  one-hot intermediate bank write enable.
- lane_mask  out  64  lanes valid for the current acc_en beat.
- acc_clr  out  1  clear accumulator; accompanies the first beat of a neuron.
- acc_en  out  1  accumulate beat; SRAM data for this beat is valid in this cycle.
- sum_in  in  ACC_W  signed reduced sum from the MAC tree.
- wr_data  out  16  writeback value to the intermediate SRAM.
- out_valid  out  1  layer-2 result strobe.
- out_idx  out  4  output neuron index, 0..9.
- out_data  out  16  signed layer-2 result.

Behaviour:
- Reset: all outputs are 0; FSM is in IDLE; all counters are 0. Reset is async and may occur mid-run; the next run restarts from neuron 0 with no stale writes.
- States: IDLE, L1_RUN, L1_DRAIN, L1_WB, L2_RUN, L2_DRAIN, L2_OUT, FINISH.
- IDLE: on start go to L1_RUN with n=0, r=0. start while busy is ignored.
- L1_RUN: one row per cycle, r = 0..12.
  - io_addr = r; w_addr = n*13 + r; w_sel = 0.
  - Addresses are issued in cycle t. In t+1 (1-cycle SRAM read latency): acc_en=1, acc_clr=(r==0), lane_mask = all-ones, or 0x0000_0000_0000_FFFF when r==12.
  - After r==12 is issued, go to L1_DRAIN.
- L1_DRAIN: wait until the last beat plus DRAIN_CYC cycles, then go to L1_WB.
- L1_WB: one cycle.
  - mid_we bit (n mod 64) = 1; mid_addr = n/64.
  - wr_data = ReLU then saturate: s = sum_in >>> FRAC_BITS; s<0 -> 0; s>32767 -> 32767.
  - If n==199 go to L2_RUN with o=0, r=0; else n+=1 and go to L1_RUN.
- L2_RUN: r = 0..3.
  - mid_addr = r; w_addr = o*4 + r; w_sel = 1.
  - Beat timing is the same as layer 1; lane_mask is all-ones, or 0x0000_0000_0000_00FF when r==3.
- L2_DRAIN: same as L1_DRAIN, then go to L2_OUT.
- L2_OUT: out_valid=1; out_idx=o; out_data = saturate(sum_in >>> FRAC_BITS) to [-32768, 32767] (no ReLU).
  - If o==9 go to FINISH; else o+=1 and go to L2_RUN.
- FINISH: done=1 for one cycle, busy drops in the same cycle, then go to IDLE.
- mid_we is never asserted outside L1_WB. acc_en is never asserted outside the RUN beats.
- Total latency from start to done: 200*(13+DRAIN_CYC+1) + 10*(4+DRAIN_CYC+1) + 2 cycles. With defaults this is 3482.
- Address maxima: w_addr 2599 in layer 1, 39 in layer 2. All counters are sized so they never wrap within a run.

Optional Feature:
- MLP_ARGMAX_EN.
  - Defined: adds outputs class_idx[3:0] and class_valid. The block tracks the running signed maximum of out_data; ties keep the lower index. class_valid pulses together with done. Both reset to 0.
  - Undefined: the ports and logic are absent.

Decomposition:
- Package mlp_pkg holds:
  - The state enum.
  - Layer dimensions (13, 200, 4, 10).
  - The two last-row lane-mask constants.
  - ACC_W and FRAC_BITS defaults.
- One sub-module, mlp_requant: shift, optional ReLU and 16-bit saturation. It is combinational and shared by L1_WB and L2_OUT via a relu_en input.

Test Plan:
- Start after reset, sum_in held at 0x0000_0100 -> every mid_we write has wr_data=1; 200 writes, bank n%64 and addr n/64; 10 out_valid with out_data=1; done at cycle 3482.
- Check neuron 0 beats -> io_addr 0..12, w_addr 0..12, acc_clr only on the first beat, lane_mask on the 13th beat = 0xFFFF; neuron 199 w_addr 2587..2599.
- sum_in = -5000 during layer 1 -> wr_data=0 (ReLU); sum_in = 0x0100_0000 -> wr_data=32767; layer 2 with sum_in=-0x0100_0000 -> out_data=-32768.
- Pulse rst_n low during neuron 57 L1_WB -> all outputs are 0 immediately, no mid_we pulse; a new start restarts at io_addr=0, w_addr=0.
- start pulsed while busy -> ignored, run length unchanged; layer-2 row 3 lane_mask=0xFF and w_addr for o=9 is 36..39.
- MLP_ARGMAX_EN with out_data sequence 3,9,2,9,... -> class_idx=1 with class_valid coincident with done.

Source files
------------

// File: rtl/mlp_pkg.sv
// Shared definitions for the two-layer MLP sequencer: FSM states, layer
// dimensions, last-row lane masks and fixed-point defaults.
package mlp_pkg;

    // Layer geometry, in SRAM rows / neurons
    localparam int N_IN_ROWS  = 13;
    localparam int N_HID      = 200;
    localparam int N_MID_ROWS = 4;
    localparam int N_OUT      = 10;

    // Datapath timing and number format
    localparam int DRAIN_CYC  = 3;
    localparam int ACC_W      = 32;
    localparam int FRAC_BITS  = 8;

    // Lane masks for the accumulate beats
    localparam logic [63:0] FULL_MASK    = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] L1_LAST_MASK = 64'h0000_0000_0000_FFFF;
    localparam logic [63:0] L2_LAST_MASK = 64'h0000_0000_0000_00FF;

    typedef enum logic [2:0] {
        IDLE,
        L1_RUN,
        L1_DRAIN,
        L1_WB,
        L2_RUN,
        L2_DRAIN,
        L2_OUT,
        FINISH
    } state_t;

endpackage

// File: rtl/mlp_requant.sv
// Requantiser: drops the fraction bits of the reduced sum, optionally clamps
// negatives to zero (ReLU) and saturates to a signed 16-bit result.
module mlp_requant
    import mlp_pkg::*;
(
    input  logic signed [ACC_W-1:0] i_sum,
    input  logic                    i_relu_en,
    output logic [15:0]             o_data
);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

    logic signed [ACC_W-1:0] w_shifted;

    assign w_shifted = i_sum >>> FRAC_BITS;

    // Clamp the shifted sum into the 16-bit output range
    always_comb begin
        // NOTE: o_data gets a value before any branch so no path leaves it unassigned (no latch).
        o_data = w_shifted[15:0];
        if (i_relu_en && (w_shifted < 0)) begin
            o_data = 16'h0000;
        end else if (w_shifted > SAT_MAX) begin
            o_data = 16'h7FFF;
        end else if (w_shifted < SAT_MIN) begin
            o_data = 16'h8000;
        end
    end

endmodule

// File: rtl/mlp_layer_sequencer.sv
// Two-layer MLP inference sequencer. Walks layer 1 (784 x 200) and layer 2
// (200 x 10), issuing SRAM addresses, one-cycle-delayed MAC beats, and
// requantised writebacks / output strobes.
// Optional build macro: MLP_ARGMAX_EN adds class_idx / class_valid, the index
// of the largest layer-2 output (lowest index wins ties).
module mlp_layer_sequencer
    import mlp_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [3:0]              io_addr,
    output logic [11:0]             w_addr,
    output logic                    w_sel,
    output logic [1:0]              mid_addr,
    output logic [63:0]             mid_we,
    output logic [63:0]             lane_mask,
    output logic                    acc_clr,
    output logic                    acc_en,
    input  logic signed [ACC_W-1:0] sum_in,
    output logic [15:0]             wr_data,
    output logic                    out_valid,
    output logic [3:0]              out_idx,
    output logic [15:0]             out_data
`ifdef MLP_ARGMAX_EN
    ,
    output logic [3:0]              class_idx,
    output logic                    class_valid
`endif
);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_n;        // hidden neuron index, 0..199
    logic [3:0]  r_o;        // output neuron index, 0..9
    logic [3:0]  r_r;        // row within the current neuron
    logic [3:0]  r_dcnt;     // drain wait counter
    logic        r_acc_en;
    logic        r_acc_clr;
    logic [63:0] r_lane_mask;

    logic        w_is_run;
    logic        w_last_row;
    logic        w_last_drain;
    logic [11:0] w_l1_addr;
    logic [11:0] w_l2_addr;
    logic        w_relu_en;
    logic [15:0] w_requant;

    assign w_is_run     = (r_state == L1_RUN) || (r_state == L2_RUN);
    assign w_last_row   = (r_state == L1_RUN) ? (r_r == 4'(N_IN_ROWS - 1))
                                              : (r_r == 4'(N_MID_ROWS - 1));
    assign w_last_drain = (r_dcnt == 4'(DRAIN_CYC - 1));
    assign w_l1_addr    = 12'(r_n) * 12'(N_IN_ROWS) + 12'(r_r);
    assign w_l2_addr    = 12'(r_o) * 12'(N_MID_ROWS) + 12'(r_r);
    assign w_relu_en    = (r_state == L1_WB);

    mlp_requant u_requant (
        .i_sum     (sum_in),
        .i_relu_en (w_relu_en),
        .o_data    (w_requant)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (start) w_next = L1_RUN;
            L1_RUN:   if (w_last_row) w_next = L1_DRAIN;
            L1_DRAIN: if (w_last_drain) w_next = L1_WB;
            L1_WB:    w_next = (r_n == 8'(N_HID - 1)) ? L2_RUN : L1_RUN;
            L2_RUN:   if (w_last_row) w_next = L2_DRAIN;
            L2_DRAIN: if (w_last_drain) w_next = L2_OUT;
            L2_OUT:   w_next = (r_o == 4'(N_OUT - 1)) ? FINISH : L2_RUN;
            FINISH:   w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    // Neuron, row and drain counters; IDLE clears them so a new run starts at neuron 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n    <= '0;
            r_o    <= '0;
            r_r    <= '0;
            r_dcnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_n    <= '0;
                    r_o    <= '0;
                    r_r    <= '0;
                    r_dcnt <= '0;
                end
                L1_RUN, L2_RUN: begin
                    r_r    <= w_last_row ? 4'd0 : r_r + 4'd1;
                    r_dcnt <= '0;
                end
                L1_DRAIN, L2_DRAIN: r_dcnt <= w_last_drain ? 4'd0 : r_dcnt + 4'd1;
                L1_WB:  if (r_n != 8'(N_HID - 1)) r_n <= r_n + 8'd1;
                L2_OUT: if (r_o != 4'(N_OUT - 1)) r_o <= r_o + 4'd1;
                default: ;
            endcase
        end
    end

    // MAC beat strobes trail the address issue by one cycle (SRAM read latency)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_en    <= 1'b0;
            r_acc_clr   <= 1'b0;
            r_lane_mask <= '0;
        end else begin
            r_acc_en  <= w_is_run;
            r_acc_clr <= w_is_run && (r_r == 4'd0);
            if (!w_is_run)                r_lane_mask <= '0;
            else if (!w_last_row)         r_lane_mask <= FULL_MASK;
            else if (r_state == L1_RUN)   r_lane_mask <= L1_LAST_MASK;
            else                          r_lane_mask <= L2_LAST_MASK;
        end
    end

    assign acc_en    = r_acc_en;
    assign acc_clr   = r_acc_clr;
    assign lane_mask = r_lane_mask;

    // Address, writeback and handshake outputs decoded from the current state
    always_comb begin
        busy      = (r_state != IDLE) && (r_state != FINISH);
        done      = 1'b0;
        io_addr   = '0;
        w_addr    = '0;
        w_sel     = 1'b0;
        mid_addr  = '0;
        mid_we    = '0;
        wr_data   = '0;
        out_valid = 1'b0;
        out_idx   = '0;
        out_data  = '0;
        case (r_state)
            L1_RUN: begin
                io_addr = r_r;
                w_addr  = w_l1_addr;
            end
            L1_WB: begin
                mid_we   = 64'd1 << r_n[5:0];
                mid_addr = r_n[7:6];
                wr_data  = w_requant;
            end
            L2_RUN: begin
                mid_addr = r_r[1:0];
                w_addr   = w_l2_addr;
                w_sel    = 1'b1;
            end
            L2_DRAIN: w_sel = 1'b1;
            L2_OUT: begin
                w_sel     = 1'b1;
                out_valid = 1'b1;
                out_idx   = r_o;
                out_data  = w_requant;
            end
            FINISH: done = 1'b1;
            default: ;
        endcase
    end

`ifdef MLP_ARGMAX_EN
    logic signed [15:0] r_max;
    logic [3:0]         r_class_idx;

    // Running maximum of the layer-2 outputs; strict compare keeps the lower index on ties
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max       <= '0;
            r_class_idx <= '0;
        end else if (r_state == L2_OUT) begin
            if ((r_o == 4'd0) || ($signed(w_requant) > r_max)) begin
                r_max       <= $signed(w_requant);
                r_class_idx <= r_o;
            end
        end
    end

    assign class_idx   = r_class_idx;
    assign class_valid = (r_state == FINISH);
`endif

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Self-checking bench for mlp_layer_sequencer. The expected schedule of every
// cycle is derived from the layer geometry with plain arithmetic (neuron slot,
// phase within the slot); expected writebacks come from an arithmetic
// floor-divide / clamp model. Build with MLP_ARGMAX_EN to also check class_idx.
module tb_mlp_layer_sequencer;

    localparam int ROWS1     = 13;
    localparam int ROWS2     = 4;
    localparam int NEUR1     = 200;
    localparam int NEUR2     = 10;
    localparam int DRAIN     = 3;
    localparam int SLOT1     = ROWS1 + DRAIN + 1;
    localparam int SLOT2     = ROWS2 + DRAIN + 1;
    localparam int L1_CYC    = NEUR1 * SLOT1;
    localparam int L2_CYC    = NEUR2 * SLOT2;
    localparam int TOTAL_LAT = L1_CYC + L2_CYC + 2;   // start cycle counted as cycle 1
    localparam int DONE_K    = TOTAL_LAT - 1;         // cycles after the start cycle
    localparam int RUN_LIMIT = DONE_K + 100;

    localparam int G_BUSY = 0;
    localparam int G_ADDR = 1;
    localparam int G_BEAT = 2;
    localparam int G_WE   = 3;
    localparam int G_WR   = 4;
    localparam int G_OUT  = 5;
    localparam int G_ARG  = 6;
`ifdef MLP_ARGMAX_EN
    localparam int N_GROUPS = 7;
`else
    localparam int N_GROUPS = 6;
`endif

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               busy;
    logic               done;
    logic [3:0]         io_addr;
    logic [11:0]        w_addr;
    logic               w_sel;
    logic [1:0]         mid_addr;
    logic [63:0]        mid_we;
    logic [63:0]        lane_mask;
    logic               acc_clr;
    logic               acc_en;
    logic signed [31:0] sum_in;
    logic [15:0]        wr_data;
    logic               out_valid;
    logic [3:0]         out_idx;
    logic [15:0]        out_data;
`ifdef MLP_ARGMAX_EN
    logic [3:0]         class_idx;
    logic               class_valid;
`endif
    logic               any_out;

    int checks = 0;
    int errors = 0;

    mlp_layer_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .io_addr   (io_addr),
        .w_addr    (w_addr),
        .w_sel     (w_sel),
        .mid_addr  (mid_addr),
        .mid_we    (mid_we),
        .lane_mask (lane_mask),
        .acc_clr   (acc_clr),
        .acc_en    (acc_en),
        .sum_in    (sum_in),
        .wr_data   (wr_data),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .out_data  (out_data)
`ifdef MLP_ARGMAX_EN
        ,
        .class_idx   (class_idx),
        .class_valid (class_valid)
`endif
    );

    assign any_out = |{busy, done, io_addr, w_addr, w_sel, mid_addr, mid_we, lane_mask,
                       acc_clr, acc_en, wr_data, out_valid, out_idx, out_data
`ifdef MLP_ARGMAX_EN
                       , class_idx, class_valid
`endif
                      };

    always #5 clk = ~clk;

    // floor(s / 2^8), optional ReLU, clamp to int16
    function automatic int requant_model(input longint s, input bit relu);
        longint q;
        q = s / 256;
        if ((s % 256) != 0 && s < 0) q = q - 1;
        if (relu && q < 0) q = 0;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return int'(q);
    endfunction

    // Map cycle k after the start cycle to (layer, neuron, phase within slot)
    function automatic void decode(input int k, output int layer, output int idx, output int p);
        if (k >= 1 && k <= L1_CYC) begin
            layer = 1; idx = (k - 1) / SLOT1; p = (k - 1) % SLOT1;
        end else if (k > L1_CYC && k <= L1_CYC + L2_CYC) begin
            layer = 2; idx = (k - L1_CYC - 1) / SLOT2; p = (k - L1_CYC - 1) % SLOT2;
        end else begin
            layer = 0; idx = 0; p = 0;
        end
    endfunction

    function automatic logic signed [31:0] pick_sum(input int mode, input int k);
        int layer, idx, p, v;
        int argseq [10];
        argseq = '{3, 9, 2, 9, 1, 0, 5, 4, 8, 7};
        decode(k, layer, idx, p);
        case (mode)
            0: return 32'sh0000_0100;
            1: begin
                case ($urandom_range(0, 5))
                    0: return -5000;
                    1: return 32'sh0100_0000;
                    2: return -32'sh0100_0000;
                    3: return 32'($urandom);
                    4: return 32'($urandom_range(0, 32'h007F_FFFF));
                    default: begin
                        v = int'($urandom_range(0, 32'h007F_FFFF));
                        return -v;
                    end
                endcase
            end
            2: begin
                if (layer == 1) begin
                    if (idx % 3 == 0)      return -5000;
                    else if (idx % 3 == 1) return 32'sh0100_0000;
                    else                   return 32'sh0000_7F80;
                end
                return (idx % 2 == 0) ? -32'sh0100_0000 : 32'sh7FFF_FFFF;
            end
            default: return (layer == 2) ? 32'(argseq[idx] * 256 + 77) : 32'sh0000_0100;
        endcase
    endfunction

    function automatic void flag(inout int cnt, inout int first, input int k);
        cnt++;
        if (first < 0) first = k;
    endfunction

    // One inference: pulse start, compare every cycle against the derived schedule
    task automatic run_inference(input int mode, input int stop_k, input int busy_k, input string tag);
        int          bad_cnt [7];
        int          bad_first [7];
        string       gname [7];
        int          done_k, n_we, n_out, layer, idx, p;
        bit          stopped;
        logic        e_acc, e_clr, e_busy, e_done, e_ov;
        logic [63:0] e_mask, e_we;
        logic [15:0] e_wr, e_od;
`ifdef MLP_ARGMAX_EN
        logic [15:0] exp_out [10];
        int          best;
`endif
        gname = '{"busy_done", "addresses", "acc_beats", "mid_we", "wr_data", "out_stream", "argmax"};
        for (int g = 0; g < 7; g++) begin
            bad_cnt[g] = 0;
            bad_first[g] = -1;
        end
        done_k = -1; n_we = 0; n_out = 0; stopped = 0;

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= RUN_LIMIT; k++) begin
            sum_in = pick_sum(mode, k);
            @(negedge clk);
            decode(k, layer, idx, p);
            e_busy = (k < DONE_K);
            e_done = (k == DONE_K);
            e_acc = 1'b0; e_clr = 1'b0; e_mask = '1; e_we = '0;
            e_ov = 1'b0; e_wr = '0; e_od = '0;
            if (layer == 1) begin
                if (p < ROWS1 && (io_addr !== 4'(p) || w_addr !== 12'(idx * ROWS1 + p) || w_sel !== 1'b0))
                    flag(bad_cnt[G_ADDR], bad_first[G_ADDR], k);
                if (p >= 1 && p <= ROWS1) begin
                    e_acc = 1'b1;
                    e_clr = (p == 1);
                    if (p == ROWS1) e_mask = 64'h0000_0000_0000_FFFF;
                end
                if (p == SLOT1 - 1) begin
                    e_we = 64'd1 << (idx % 64);
                    e_wr = 16'(requant_model(sum_in, 1'b1));
                    if (mid_addr !== 2'(idx / 64)) flag(bad_cnt[G_ADDR], bad_first[G_ADDR], k);
                end
            end else if (layer == 2) begin
                if (p < ROWS2 && (mid_addr !== 2'(p) || w_addr !== 12'(idx * ROWS2 + p) || w_sel !== 1'b1))
                    flag(bad_cnt[G_ADDR], bad_first[G_ADDR], k);
                if (p >= 1 && p <= ROWS2) begin
                    e_acc = 1'b1;
                    e_clr = (p == 1);
                    if (p == ROWS2) e_mask = 64'h0000_0000_0000_00FF;
                end
                if (p == SLOT2 - 1) begin
                    e_ov = 1'b1;
                    e_od = 16'(requant_model(sum_in, 1'b0));
`ifdef MLP_ARGMAX_EN
                    exp_out[idx] = e_od;
`endif
                end
            end
            if (busy !== e_busy || done !== e_done) flag(bad_cnt[G_BUSY], bad_first[G_BUSY], k);
            if (acc_en !== e_acc || acc_clr !== e_clr || (e_acc && lane_mask !== e_mask))
                flag(bad_cnt[G_BEAT], bad_first[G_BEAT], k);
            if (mid_we !== e_we) flag(bad_cnt[G_WE], bad_first[G_WE], k);
            if (e_we != 0 && wr_data !== e_wr) flag(bad_cnt[G_WR], bad_first[G_WR], k);
            if (out_valid !== e_ov || (e_ov && (out_idx !== 4'(idx) || out_data !== e_od)))
                flag(bad_cnt[G_OUT], bad_first[G_OUT], k);
`ifdef MLP_ARGMAX_EN
            if (class_valid !== e_done) flag(bad_cnt[G_ARG], bad_first[G_ARG], k);
            if (e_done) begin
                best = 0;
                for (int i = 1; i < NEUR2; i++)
                    if ($signed(exp_out[i]) > $signed(exp_out[best])) best = i;
                if (class_idx !== 4'(best)) flag(bad_cnt[G_ARG], bad_first[G_ARG], k);
            end
`endif
            if (mid_we != 0) n_we++;
            if (out_valid === 1'b1) n_out++;
            start = (k == busy_k);
            if (k == stop_k) begin
                stopped = 1;
                break;
            end
            if (done === 1'b1) begin
                done_k = k;
                break;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;

        for (int g = 0; g < N_GROUPS; g++) begin
            checks++;
            if (bad_cnt[g] !== 0) begin
                errors++;
                $display("FAIL %s/%s: %0d bad cycles (first at cycle %0d after start), required 0",
                         tag, gname[g], bad_cnt[g], bad_first[g]);
            end
        end
        if (!stopped) begin
            checks++;
            if (done_k + 1 !== TOTAL_LAT) begin
                errors++;
                $display("FAIL %s/done_cycle: got %0d, required %0d (start cycle = 1, -1 means no done)",
                         tag, (done_k < 0) ? -1 : done_k + 1, TOTAL_LAT);
            end
            checks++;
            if (n_we !== NEUR1) begin
                errors++;
                $display("FAIL %s/mid_we_count: got %0d, required %0d", tag, n_we, NEUR1);
            end
            checks++;
            if (n_out !== NEUR2) begin
                errors++;
                $display("FAIL %s/out_valid_count: got %0d, required %0d", tag, n_out, NEUR2);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; sum_in = 32'sh0000_0100;
        repeat (3) @(negedge clk);
        checks++;
        if (any_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: some output nonzero (%b), required all 0", any_out);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (any_out !== 1'b0) begin
            errors++;
            $display("FAIL idle_outputs: some output nonzero (%b), required all 0", any_out);
        end
    endtask

    task automatic test_constant_sum();
        run_inference(0, 0, 0, "const_0x100");
    endtask

    task automatic test_requant_bounds();
        run_inference(2, 0, 0, "bounds");
    endtask

    task automatic test_start_while_busy();
        run_inference(1, 0, 1700, "busy_start");
    endtask

    task automatic test_mid_reset();
        int seen;
        // Stop on the writeback cycle of neuron 57, then reset asynchronously
        run_inference(1, 57 * SLOT1 + SLOT1, 0, "pre_reset");
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (any_out !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_outputs: some output nonzero (%b), required all 0", any_out);
        end
        seen = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (mid_we != 0 || any_out !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_hold_quiet: %0d cycles with activity, required 0", seen);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_inference(1, 0, 0, "after_reset");
    endtask

    task automatic test_argmax();
        run_inference(3, 0, 0, "argmax_seq");
    endtask

    initial begin
        clk = 1'b0;
        test_reset();
        test_constant_sum();
        test_requant_bounds();
        test_start_while_busy();
        test_mid_reset();
        test_argmax();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
